// File: rtl/mem_arbiter.sv
// Two-port arbiter for a six-slot matrix memory: one fixed four-state transaction per grant.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin between simultaneous requesters; the default is fixed priority to port 0.
module mem_arbiter (
   input  logic         clk,
   input  logic         reset,
   input  logic         rq0_req,
   input  logic         rq0_we,
   input  logic [2:0]   rq0_addr,
   input  logic [255:0] rq0_wdata,
   input  logic         rq1_req,
   input  logic         rq1_we,
   input  logic [2:0]   rq1_addr,
   input  logic [255:0] rq1_wdata,
   output logic         rq0_gnt,
   output logic         rq1_gnt,
   output logic         rq0_done,
   output logic         rq1_done,
   output logic [255:0] rdata,
   output logic         err,
   output logic [2:0]   mem_pointer,
   output logic         mem_write,
   output logic         mem_read,
   output logic [255:0] mem_wdata,
   input  logic [255:0] mem_rdata
);

   localparam logic [2:0] LAST_SLOT = 3'd5;

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

   state_t       state;
   logic         port_q;
   logic         we_q;
   logic [2:0]   addr_q;
   logic         any_req;
   logic         winner;
   logic         win_we;
   logic [2:0]   win_addr;
   logic [255:0] win_wdata;

   assign any_req = rq0_req | rq1_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_served;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_served <= 1'b1;
      else if (state == IDLE && any_req)
         last_served <= winner;
   end
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      winner = ~rq0_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (rq0_req && rq1_req)
         winner = ~last_served;
`endif
   end

   assign win_we    = winner ? rq1_we    : rq0_we;
   assign win_addr  = winner ? rq1_addr  : rq0_addr;
   assign win_wdata = winner ? rq1_wdata : rq0_wdata;

   // Write data is captured straight into mem_wdata at the grant edge; it is only needed during ACCESS.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the wide data registers are reset too, since rdata and mem_wdata must read 0 out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         port_q      <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         rq0_gnt     <= 1'b0;
         rq1_gnt     <= 1'b0;
         rq0_done    <= 1'b0;
         rq1_done    <= 1'b0;
         err         <= 1'b0;
         rdata       <= '0;
         mem_pointer <= '0;
         mem_write   <= 1'b0;
         mem_read    <= 1'b0;
         mem_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state   <= ACCESS;
                  port_q  <= winner;
                  we_q    <= win_we;
                  addr_q  <= win_addr;
                  rq0_gnt <= ~winner;
                  rq1_gnt <= winner;
                  if (win_addr <= LAST_SLOT) begin
                     mem_pointer <= win_addr;
                     mem_wdata   <= win_wdata;
                     mem_write   <= win_we;
                     mem_read    <= ~win_we;
                  end
               end
            end
            ACCESS: begin
               state       <= CAPTURE;
               mem_pointer <= '0;
               mem_wdata   <= '0;
               mem_write   <= 1'b0;
               mem_read    <= 1'b0;
            end
            CAPTURE: begin
               state    <= DONE;
               rq0_done <= ~port_q;
               rq1_done <= port_q;
               err      <= (addr_q > LAST_SLOT);
               if (!we_q && addr_q <= LAST_SLOT)
                  rdata <= mem_rdata;
            end
            DONE: begin
               state    <= IDLE;
               rq0_gnt  <= 1'b0;
               rq1_gnt  <= 1'b0;
               rq0_done <= 1'b0;
               rq1_done <= 1'b0;
               err      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level reference model queues expected
// results at each grant, and a monitor compares memory strobes and done pulses as they appear.
module tb_mem_arbiter;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         rq0_req = 1'b0, rq1_req = 1'b0;
   logic         rq0_we = 1'b0, rq1_we = 1'b0;
   logic [2:0]   rq0_addr = '0, rq1_addr = '0;
   logic [255:0] rq0_wdata = '0, rq1_wdata = '0;
   logic         rq0_gnt, rq1_gnt, rq0_done, rq1_done, err;
   logic [255:0] rdata, mem_wdata;
   logic [255:0] mem_rdata = '0;
   logic [2:0]   mem_pointer;
   logic         mem_write, mem_read;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
      .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
      .rq0_gnt(rq0_gnt), .rq1_gnt(rq1_gnt), .rq0_done(rq0_done), .rq1_done(rq1_done),
      .rdata(rdata), .err(err), .mem_pointer(mem_pointer), .mem_write(mem_write),
      .mem_read(mem_read), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   typedef struct {
      logic         port;
      logic         we;
      logic [2:0]   addr;
      logic [255:0] wdata;
      logic [255:0] rdata;
      logic         err;
      int           gcyc;
   } txn_t;

   txn_t         sb_q[$];
   txn_t         acc_q[$];
   txn_t         m_cur;
   logic [255:0] ref_mem [6];
   logic [255:0] tb_mem [6];
   logic [255:0] m_rdata;
   int           m_left;
   logic         m_last;
   int           cyc;
   int           n_vec, n_fail;
   int           grant_log[$];
   logic         prev_g0, prev_g1;

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s: event with no expectation queued (t=%0t)", name, $time);
   endtask

   // Memory behind the arbiter: write on strobe, read data valid the cycle after mem_read, noise otherwise.
   always @(posedge clk) begin
      if (mem_write && mem_pointer <= 3'd5) tb_mem[mem_pointer] <= mem_wdata;
      if (mem_read && mem_pointer <= 3'd5) mem_rdata <= tb_mem[mem_pointer];
      else mem_rdata <= rand256();
   end

   // Reference model: one transaction at a time, each occupying the memory for three cycles after its grant edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_left  = 0;
         m_rdata = '0;
         m_last  = 1'b1;
         sb_q.delete();
         acc_q.delete();
      end else begin
         cyc++;
         if (m_left == 0) begin
            if (rq0_req || rq1_req) begin
               txn_t t;
               if (rq0_req && rq1_req) t.port = RR_EN ? ~m_last : 1'b0;
               else t.port = rq1_req;
               m_last  = t.port;
               t.we    = t.port ? rq1_we : rq0_we;
               t.addr  = t.port ? rq1_addr : rq0_addr;
               t.wdata = t.port ? rq1_wdata : rq0_wdata;
               t.err   = (t.addr > 3'd5);
               t.gcyc  = cyc;
               t.rdata = m_rdata;
               if (!t.err && t.we) ref_mem[t.addr] = t.wdata;
               if (!t.err && !t.we) t.rdata = ref_mem[t.addr];
               sb_q.push_back(t);
               if (!t.err) acc_q.push_back(t);
               m_cur  = t;
               m_left = 3;
            end
         end else begin
            m_left--;
            if (m_left == 1) m_rdata = m_cur.rdata;
         end
      end
   end

   // Monitor: samples on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (!reset) begin
         txn_t t;
         check("gnt0", 256'(rq0_gnt), 256'(m_left > 0 && !m_cur.port));
         check("gnt1", 256'(rq1_gnt), 256'(m_left > 0 && m_cur.port));
         check("done_timing", 256'({rq1_done, rq0_done}),
               256'((m_left == 1) ? (m_cur.port ? 2'b10 : 2'b01) : 2'b00));
         check("rdata_hold", rdata, m_rdata);
         if (rq0_done || rq1_done) begin
            if (sb_q.size() == 0) fail("done_unexpected");
            else begin
               t = sb_q.pop_front();
               check("done_port", 256'(rq1_done), 256'(t.port));
               check("done_err", 256'(err), 256'(t.err));
               check("done_rdata", rdata, t.rdata);
               check("done_latency", 256'(cyc - t.gcyc + 1), 256'(3));
            end
         end else
            check("err_alone", 256'(err), 256'(0));
         check("strobe_present", 256'(mem_write | mem_read), 256'(m_left == 3 && !m_cur.err));
         if (mem_write || mem_read) begin
            if (acc_q.size() == 0) fail("strobe_unexpected");
            else begin
               t = acc_q.pop_front();
               check("strobe_kind", 256'({mem_write, mem_read}), 256'(t.we ? 2'b10 : 2'b01));
               check("mem_pointer", 256'(mem_pointer), 256'(t.addr));
               check("mem_wdata", mem_wdata, t.wdata);
            end
         end else begin
            check("idle_pointer", 256'(mem_pointer), 256'(0));
            check("idle_wdata", mem_wdata, 256'(0));
         end
         if (rq0_gnt && !prev_g0) grant_log.push_back(0);
         if (rq1_gnt && !prev_g1) grant_log.push_back(1);
      end
      prev_g0 = rq0_gnt;
      prev_g1 = rq1_gnt;
   end

   task automatic set_port(input logic port, input logic req, input logic we,
                           input logic [2:0] addr, input logic [255:0] wd);
      if (port) begin
         rq1_req = req; rq1_we = we; rq1_addr = addr; rq1_wdata = wd;
      end else begin
         rq0_req = req; rq0_we = we; rq0_addr = addr; rq0_wdata = wd;
      end
   endtask

   // Called just after a falling edge with the arbiter idle; returns after the transaction has retired.
   task automatic issue(input logic port, input logic we, input logic [2:0] addr, input logic [255:0] wd);
      set_port(port, 1'b1, we, addr, wd);
      @(negedge clk);
      set_port(port, 1'b0, 1'b0, 3'd0, 256'(0));
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [255:0] pat_a5;
      pat_a5 = {32{8'hA5}};
      for (int i = 0; i < 6; i++) begin
         logic [255:0] v;
         v = rand256();
         tb_mem[i]  = v;
         ref_mem[i] = v;
      end
      repeat (3) @(negedge clk);
      check("reset_rdata", rdata, 256'(0));
      check("reset_ctrl", 256'({rq0_gnt, rq1_gnt, rq0_done, rq1_done, err, mem_write, mem_read, mem_pointer}),
            256'(0));
      reset = 1'b0;
      @(negedge clk);

      // Both ports hold requests for four transaction slots.
      grant_log.delete();
      set_port(1'b0, 1'b1, 1'b0, 3'd1, 256'(0));
      set_port(1'b1, 1'b1, 1'b0, 3'd2, 256'(0));
      repeat (16) @(negedge clk);
      set_port(1'b0, 1'b0, 1'b0, 3'd0, 256'(0));
      set_port(1'b1, 1'b0, 1'b0, 3'd0, 256'(0));
      repeat (4) @(negedge clk);
      check("contend_count", 256'(grant_log.size()), 256'(4));
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check("contend_order", 256'(grant_log[i]), 256'(RR_EN ? (i % 2) : 0));

      // Write then read back slot 2 from port 0.
      issue(1'b0, 1'b1, 3'd2, pat_a5);
      issue(1'b0, 1'b0, 3'd2, 256'(0));
      check("readback_a5", rdata, pat_a5);

      // Illegal address from port 1 leaves rdata alone.
      issue(1'b1, 1'b0, 3'd7, rand256());
      check("err_keeps_rdata", rdata, pat_a5);

      // Inputs change right after the grant edge; memory must see the originals.
      set_port(1'b0, 1'b1, 1'b1, 3'd3, {8{32'h1234_5678}});
      @(posedge clk);
      #1 set_port(1'b0, 1'b0, 1'b1, 3'd4, {8{32'hDEAD_BEEF}});
      repeat (5) @(negedge clk);
      issue(1'b0, 1'b0, 3'd3, 256'(0));
      check("late_change_readback", rdata, {8{32'h1234_5678}});

      // Reset lands in CAPTURE of a read.
      set_port(1'b0, 1'b1, 1'b0, 3'd0, 256'(0));
      @(posedge clk);
      @(negedge clk);
      set_port(1'b0, 1'b0, 1'b0, 3'd0, 256'(0));
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_rdata", rdata, 256'(0));
      check("abort_ctrl", 256'({rq0_gnt, rq1_gnt, rq0_done, rq1_done, err, mem_write, mem_read}), 256'(0));
      check("abort_bus", 256'({mem_pointer, mem_wdata[252:0]}), 256'(0));
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      issue(1'b0, 1'b0, 3'd2, 256'(0));
      check("after_abort_read", rdata, pat_a5);

      // Randomized traffic on both ports.
      for (int i = 0; i < 400; i++) begin
         rq0_req   = ($urandom_range(0, 9) < 4);
         rq1_req   = ($urandom_range(0, 9) < 4);
         rq0_we    = $urandom_range(0, 1) == 1;
         rq1_we    = $urandom_range(0, 1) == 1;
         rq0_addr  = 3'($urandom_range(0, 7));
         rq1_addr  = 3'($urandom_range(0, 7));
         rq0_wdata = rand256();
         rq1_wdata = rand256();
         @(negedge clk);
      end
      set_port(1'b0, 1'b0, 1'b0, 3'd0, 256'(0));
      set_port(1'b1, 1'b0, 1'b0, 3'd0, 256'(0));
      repeat (8) @(negedge clk);
      check("sb_drained", 256'(sb_q.size()), 256'(0));
      check("acc_drained", 256'(acc_q.size()), 256'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
